// File: rtl/phys_reg_pkg.sv
// Physical register sizing shared by rename, free list and PhysRegFile.
// One place to change the physical/architectural register counts.
package phys_reg_pkg;

  localparam int NUM_PHYS_REGS = 64;
  localparam int NUM_ARCH_REGS = 32;
  localparam int LOG_PHYS      = $clog2(NUM_PHYS_REGS);

  typedef logic [LOG_PHYS-1:0] preg_t;
  typedef logic [LOG_PHYS:0]   fl_ptr_t;

endpackage

// File: rtl/phys_free_list.sv
// Circular free list of physical registers for rename.
// Speculative head, committed head and tail pointers with wrap bits.
module phys_free_list #(
  parameter int NUM_PHYS_REGS = phys_reg_pkg::NUM_PHYS_REGS,
  parameter int NUM_ARCH_REGS = phys_reg_pkg::NUM_ARCH_REGS,
  localparam int LW = $clog2(NUM_PHYS_REGS)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          STALL,
  input  logic          Alloc_Req_IN,
  output logic          Alloc_Grant_OUT,
  output logic [LW-1:0] Alloc_Reg_OUT,
  input  logic          Free_Valid_IN,
  input  logic [LW-1:0] Free_Reg_IN,
  input  logic          Commit_Valid_IN,
  input  logic          Flush_IN,
  output logic [LW:0]   Free_Count_OUT,
  output logic          Empty_OUT,
  output logic          Error_OUT
);

  import phys_reg_pkg::*;

  typedef logic [LW:0] ptr_t;

  localparam ptr_t FULL_CNT = ptr_t'(NUM_PHYS_REGS);
  localparam ptr_t RST_TAIL = ptr_t'(NUM_PHYS_REGS - NUM_ARCH_REGS);
  localparam ptr_t ONE      = ptr_t'(1);

  logic [LW-1:0] list_q [NUM_PHYS_REGS];
  logic [LW-1:0] list_d [NUM_PHYS_REGS];

  ptr_t head_q, head_d;
  ptr_t chead_q, chead_d;
  ptr_t tail_q, tail_d;
  logic err_q, err_d;

  ptr_t count;
  logic full;
  logic grant;
  logic free_ok;
  logic commit_ok;

  // Occupancy, grant and the register offered to rename this cycle
  always_comb begin
    count     = tail_q - head_q;
    full      = (count == FULL_CNT);
    grant     = Alloc_Req_IN & (head_q != tail_q)
              & ~STALL & ~Flush_IN;
    free_ok   = Free_Valid_IN & ~full;
    commit_ok = Commit_Valid_IN & (chead_q != head_q);
    Alloc_Grant_OUT = grant;
    Alloc_Reg_OUT   = list_q[head_q[LW-1:0]];
    Free_Count_OUT  = count;
    Empty_OUT       = (head_q == tail_q);
    Error_OUT       = err_q;
  end

  // Next pointers and list contents; flush rolls head back after commit
  always_comb begin
    list_d  = list_q;
    head_d  = head_q;
    chead_d = chead_q;
    tail_d  = tail_q;
    err_d   = err_q;
    if (free_ok) begin
      list_d[tail_q[LW-1:0]] = Free_Reg_IN;
      tail_d = tail_q + ONE;
    end
    if (commit_ok) begin
      chead_d = chead_q + ONE;
    end
    if (Flush_IN) begin
      head_d = chead_d;
    end else if (grant) begin
      head_d = head_q + ONE;
    end
    if ((Free_Valid_IN & full) | (Commit_Valid_IN & ~commit_ok)) begin
      err_d = 1'b1;
    end
  end

  // State registers; reset restores the identity-mapped initial list
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_PHYS_REGS; i++) begin
        if (i < NUM_PHYS_REGS - NUM_ARCH_REGS) begin
          list_q[i] <= LW'(NUM_ARCH_REGS + i);
        end else begin
          list_q[i] <= '0;
        end
      end
      head_q  <= '0;
      chead_q <= '0;
      tail_q  <= RST_TAIL;
      err_q   <= 1'b0;
    end else begin
      list_q  <= list_d;
      head_q  <= head_d;
      chead_q <= chead_d;
      tail_q  <= tail_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_phys_free_list.sv
// Directed and model-checked bench for phys_free_list.
// Inputs change just after the falling edge; outputs sampled 1ns later.
module tb_phys_free_list;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       STALL;
  logic       Alloc_Req_IN;
  logic       Alloc_Grant_OUT;
  logic [5:0] Alloc_Reg_OUT;
  logic       Free_Valid_IN;
  logic [5:0] Free_Reg_IN;
  logic       Commit_Valid_IN;
  logic       Flush_IN;
  logic [6:0] Free_Count_OUT;
  logic       Empty_OUT;
  logic       Error_OUT;

  int total = 0;
  int bad   = 0;

  logic [31:0] g_grant, g_reg, g_cnt;

  phys_free_list dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .STALL           (STALL),
    .Alloc_Req_IN    (Alloc_Req_IN),
    .Alloc_Grant_OUT (Alloc_Grant_OUT),
    .Alloc_Reg_OUT   (Alloc_Reg_OUT),
    .Free_Valid_IN   (Free_Valid_IN),
    .Free_Reg_IN     (Free_Reg_IN),
    .Commit_Valid_IN (Commit_Valid_IN),
    .Flush_IN        (Flush_IN),
    .Free_Count_OUT  (Free_Count_OUT),
    .Empty_OUT       (Empty_OUT),
    .Error_OUT       (Error_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    STALL = 0;
    Alloc_Req_IN = 0;
    Free_Valid_IN = 0;
    Free_Reg_IN = '0;
    Commit_Valid_IN = 0;
    Flush_IN = 0;
  endtask

  task automatic step(input logic req, input logic stall,
                      input logic fv, input logic [5:0] fr,
                      input logic cm, input logic fl);
    Alloc_Req_IN = req;
    STALL = stall;
    Free_Valid_IN = fv;
    Free_Reg_IN = fr;
    Commit_Valid_IN = cm;
    Flush_IN = fl;
    #1;
    g_grant = 32'(Alloc_Grant_OUT);
    g_reg = 32'(Alloc_Reg_OUT);
    g_cnt = 32'(Free_Count_OUT);
    @(negedge CLK);
    idle();
    #1;
  endtask

  task automatic do_reset();
    RESET = 1;
    #1;
    @(negedge CLK);
    RESET = 0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  int mlist [64];
  int mh, mc, mt;
  logic r_req, r_stall, r_fv, r_cm, r_fl, egrant;
  logic [5:0] r_fr;

  initial begin
    idle();
    RESET = 1;
    #2;
    chk("rst_cnt", 32'(Free_Count_OUT), 32);
    chk("rst_empty", 32'(Empty_OUT), 0);
    chk("rst_err", 32'(Error_OUT), 0);
    chk("rst_reg", 32'(Alloc_Reg_OUT), 32);
    Alloc_Req_IN = 1;
    #1;
    chk("rst_grant", 32'(Alloc_Grant_OUT), 1);
    STALL = 1;
    #1;
    chk("rst_grant_stall", 32'(Alloc_Grant_OUT), 0);
    STALL = 0;
    Flush_IN = 1;
    #1;
    chk("rst_grant_flush", 32'(Alloc_Grant_OUT), 0);
    idle();
    @(negedge CLK);
    RESET = 0;
    #1;

    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0, 0);
      chk("a3_grant", g_grant, 1);
      chk("a3_reg", g_reg, 32 + i);
    end
    chk("a3_cnt", 32'(Free_Count_OUT), 29);

    RESET = 1;
    #1;
    chk("midrst_cnt", 32'(Free_Count_OUT), 32);
    chk("midrst_reg", 32'(Alloc_Reg_OUT), 32);
    @(negedge CLK);
    RESET = 0;
    #1;

    for (int i = 0; i < 32; i++) begin
      step(1, 0, 0, 0, 0, 0);
      chk("drain_reg", g_reg, 32 + i);
    end
    chk("drain_empty", 32'(Empty_OUT), 1);
    chk("drain_cnt", 32'(Free_Count_OUT), 0);
    step(1, 0, 0, 0, 0, 0);
    chk("empty_nogrant", g_grant, 0);
    step(1, 0, 1, 6'd5, 0, 0);
    chk("nobypass_grant", g_grant, 0);
    chk("after_free_cnt", 32'(Free_Count_OUT), 1);
    step(1, 0, 0, 0, 0, 0);
    chk("refill_grant", g_grant, 1);
    chk("refill_reg", g_reg, 5);
    chk("refill_empty", 32'(Empty_OUT), 1);

    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1);
    chk("flush_grant", g_grant, 0);
    chk("flush_cnt", 32'(Free_Count_OUT), 30);
    step(1, 0, 0, 0, 0, 0);
    chk("flush_next", g_reg, 34);
    chk("flush_err", 32'(Error_OUT), 0);
    step(0, 0, 0, 0, 1, 1);
    chk("cmfl_cnt", 32'(Free_Count_OUT), 29);
    chk("cmfl_reg", 32'(Alloc_Reg_OUT), 35);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("commit_ok_err", 32'(Error_OUT), 0);
    step(0, 0, 0, 0, 1, 0);
    chk("commit_bad_err", 32'(Error_OUT), 1);

    do_reset();
    chk("rst_clr_err", 32'(Error_OUT), 0);
    for (int i = 0; i < 32; i++) step(0, 0, 1, 6'(i), 0, 0);
    chk("full_cnt", 32'(Free_Count_OUT), 64);
    chk("full_empty", 32'(Empty_OUT), 0);
    chk("full_err0", 32'(Error_OUT), 0);
    step(0, 0, 1, 6'd9, 0, 0);
    chk("ovf_cnt", 32'(Free_Count_OUT), 64);
    chk("ovf_err", 32'(Error_OUT), 1);
    chk("ovf_reg", 32'(Alloc_Reg_OUT), 32);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("err_sticky", 32'(Error_OUT), 1);

    do_reset();
    step(1, 1, 1, 6'd7, 0, 0);
    chk("stall_grant", g_grant, 0);
    chk("stall_cnt", 32'(Free_Count_OUT), 33);
    chk("stall_reg", 32'(Alloc_Reg_OUT), 32);

    do_reset();
    for (int i = 0; i < 64; i++) mlist[i] = (i < 32) ? 32 + i : 0;
    mh = 0;
    mc = 0;
    mt = 32;
    for (int n = 0; n < 200; n++) begin
      r_req = ($urandom % 4) != 0;
      r_stall = ($urandom % 8) == 0;
      r_fl = ($urandom % 16) == 0;
      r_cm = (mc < mh) && (($urandom % 2) == 0);
      r_fv = (mt - mc < 64) && (($urandom % 3) != 0);
      r_fr = 6'($urandom);
      step(r_req, r_stall, r_fv, r_fr, r_cm, r_fl);
      egrant = r_req && !r_stall && !r_fl && (mt != mh);
      chk("rnd_cnt", g_cnt, 32'(mt - mh));
      chk("rnd_grant", g_grant, 32'(egrant));
      if (egrant) chk("rnd_reg", g_reg, 32'(mlist[mh % 64]));
      if (r_fv) begin
        mlist[mt % 64] = int'(r_fr);
        mt++;
      end
      if (r_cm) mc++;
      if (r_fl) mh = mc;
      else if (egrant) mh++;
    end
    chk("rnd_final_cnt", 32'(Free_Count_OUT), 32'(mt - mh));
    chk("rnd_err", 32'(Error_OUT), 0);
    chk("rnd_wrapped", 32'(mh >= 64 || mt >= 64 + 32), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
